// File: rtl/sdr_pkg.sv
// Shared SDRAM command encodings and init/refresh FSM states.
// RREF states exist only when SDR_AUTO_REFRESH_EN is defined.
package sdr_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  typedef enum logic [3:0] {
    CmdLmr  = 4'b0000,
    CmdAref = 4'b0001,
    CmdPre  = 4'b0010,
    CmdNop  = 4'b0111
  } cmd_t;

  typedef enum logic [3:0] {
    StPwrup,
    StPre,
    StPreWait,
    StAref,
    StArefWait,
    StLmr,
    StLmrWait,
    StDone
`ifdef SDR_AUTO_REFRESH_EN
    ,
    StRref,
    StRrefWait
`endif
  } state_t;

  localparam int unsigned BaW   = 2;
  localparam int unsigned AddrW = 13;

  // A10 high selects all banks for PRECHARGE.
  localparam logic [AddrW-1:0] PreAllAddr = 13'h0400;

endpackage

// File: rtl/sdr_init_refresh_if.sv
// SDRAM command-bus bundle between the init/refresh block and its consumers.
interface sdr_init_refresh_if;
  import sdr_pkg::*;

  logic             sdr_cke;
  logic             sdr_cs_n;
  logic             sdr_ras_n;
  logic             sdr_cas_n;
  logic             sdr_we_n;
  logic [BaW-1:0]   sdr_ba;
  logic [AddrW-1:0] sdr_addr;
  logic             cmd_own;
  logic             sdr_init_done;
  logic             ref_req;
  logic             ref_overrun;
  logic             ref_gnt;

  modport master (
    output sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_ba, sdr_addr,
    output cmd_own, sdr_init_done, ref_req, ref_overrun,
    input  ref_gnt
  );

  modport slave (
    input  sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_ba, sdr_addr,
    input  cmd_own, sdr_init_done, ref_req, ref_overrun,
    output ref_gnt
  );

endinterface

// File: rtl/sdr_ref_timer.sv
// Periodic refresh interval timer with sticky request and overrun pulse.
module sdr_ref_timer #(
  parameter int unsigned REF_INTERVAL = 780
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic clear_i,
  output logic ref_req_o,
  output logic ref_overrun_o
);

  localparam int unsigned CntW = (REF_INTERVAL > 2) ? $clog2(REF_INTERVAL) : 1;

  logic            running_q, running_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            req_q, req_d;
  logic            ovr_q, ovr_d;
  logic            expire;

  assign expire = running_q && (cnt_q == CntW'(REF_INTERVAL - 1));

  always_comb begin
    running_d = running_q;
    cnt_d     = cnt_q;
    if (start_i) begin
      running_d = 1'b1;
      cnt_d     = '0;
    end else if (running_q) begin
      cnt_d = expire ? '0 : cnt_q + CntW'(1);
    end
    // Expiry wins over a same-edge clear so no interval is lost.
    req_d = expire | (req_q & ~clear_i);
    ovr_d = expire & req_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      running_q <= 1'b0;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      running_q <= running_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      ovr_q     <= ovr_d;
    end
  end

  assign ref_req_o     = req_q;
  assign ref_overrun_o = ovr_q;

endmodule

// File: rtl/sdr_init_refresh.sv
// SDRAM power-up init sequencer and periodic auto-refresh issuer.
// Periodic refresh (timer, RREF states) is built only with SDR_AUTO_REFRESH_EN.
module sdr_init_refresh
  import sdr_pkg::*;
#(
  parameter int unsigned      PWRUP_CYCLES   = 20000,
  parameter int unsigned      TRP            = 3,
  parameter int unsigned      TRFC           = 7,
  parameter int unsigned      TMRD           = 2,
  parameter int unsigned      INIT_REFRESHES = 2,
  parameter logic [AddrW-1:0] MODE_REG       = 13'h033,
  parameter int unsigned      REF_INTERVAL   = 780
) (
  input logic                sdram_clk,
  input logic                sdram_rst,
  sdr_init_refresh_if.master bus
);

  // Wait states count down from T-2, so TRP, TRFC and TMRD must be at least 2.
  localparam int unsigned CntW = $clog2(PWRUP_CYCLES + TRP + TRFC + TMRD + 1);

  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      nref_q, nref_d;

  cmd_t             cmd_q, cmd_d;
  logic             cke_q, cke_d;
  logic [BaW-1:0]   ba_q, ba_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic             own_q, own_d;
  logic             done_q, done_d;

  logic ref_req;
  logic ref_overrun;

  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      state_q <= StPwrup;
      cnt_q   <= '0;
      nref_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nref_q  <= nref_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nref_d  = nref_q;
    unique case (state_q)
      StPwrup: begin
        if (cnt_q == CntW'(PWRUP_CYCLES - 1)) begin
          state_d = StPre;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StPre: begin
        state_d = StPreWait;
        cnt_d   = CntW'(TRP - 2);
      end
      StPreWait: begin
        if (cnt_q == '0) state_d = StAref;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      StAref: begin
        state_d = StArefWait;
        cnt_d   = CntW'(TRFC - 2);
        nref_d  = nref_q + 4'd1;
      end
      StArefWait: begin
        if (cnt_q == '0) state_d = (nref_q == 4'(INIT_REFRESHES)) ? StLmr : StAref;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      StLmr: begin
        state_d = StLmrWait;
        cnt_d   = CntW'(TMRD - 2);
      end
      StLmrWait: begin
        if (cnt_q == '0) state_d = StDone;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      StDone: begin
`ifdef SDR_AUTO_REFRESH_EN
        if (bus.ref_gnt && ref_req) state_d = StRref;
`endif
      end
`ifdef SDR_AUTO_REFRESH_EN
      StRref: begin
        state_d = StRrefWait;
        cnt_d   = CntW'(TRFC - 2);
      end
      StRrefWait: begin
        if (cnt_q == '0) state_d = StDone;
        else             cnt_d   = cnt_q - CntW'(1);
      end
`endif
      default: state_d = StPwrup;
    endcase
  end

  // Outputs are decoded from the next state and registered, so each pin
  // changes on the same edge as the state it belongs to.
  always_comb begin
    cmd_d  = CmdNop;
    cke_d  = 1'b1;
    ba_d   = '0;
    addr_d = '0;
    own_d  = 1'b1;
    unique case (state_d)
      StPwrup: cke_d = 1'b0;
      StPre: begin
        cmd_d  = CmdPre;
        addr_d = PreAllAddr;
      end
      StAref: cmd_d = CmdAref;
      StLmr: begin
        cmd_d  = CmdLmr;
        addr_d = MODE_REG;
      end
      StDone: own_d = 1'b0;
`ifdef SDR_AUTO_REFRESH_EN
      StRref: cmd_d = CmdAref;
`endif
      default: ;
    endcase
    done_d = done_q | (state_d == StDone);
  end

  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      cmd_q  <= CmdNop;
      cke_q  <= 1'b0;
      ba_q   <= '0;
      addr_q <= '0;
      own_q  <= 1'b1;
      done_q <= 1'b0;
    end else begin
      cmd_q  <= cmd_d;
      cke_q  <= cke_d;
      ba_q   <= ba_d;
      addr_q <= addr_d;
      own_q  <= own_d;
      done_q <= done_d;
    end
  end

`ifdef SDR_AUTO_REFRESH_EN
  logic tmr_start;
  logic tmr_clear;

  // Timer starts only when init completes, not on return from RREF_WAIT.
  assign tmr_start = (state_q == StLmrWait) && (state_d == StDone);
  assign tmr_clear = (state_q == StDone) && (state_d == StRref);

  sdr_ref_timer #(
    .REF_INTERVAL (REF_INTERVAL)
  ) u_ref_timer (
    .clk_i         (sdram_clk),
    .rst_i         (sdram_rst),
    .start_i       (tmr_start),
    .clear_i       (tmr_clear),
    .ref_req_o     (ref_req),
    .ref_overrun_o (ref_overrun)
  );
`else
  logic        unused_ref_gnt;
  logic [31:0] unused_ref_interval;

  assign unused_ref_gnt      = bus.ref_gnt;
  assign unused_ref_interval = 32'(REF_INTERVAL);
  assign ref_req             = 1'b0;
  assign ref_overrun         = 1'b0;
`endif

  assign bus.sdr_cke       = cke_q;
  assign bus.sdr_cs_n      = cmd_q[3];
  assign bus.sdr_ras_n     = cmd_q[2];
  assign bus.sdr_cas_n     = cmd_q[1];
  assign bus.sdr_we_n      = cmd_q[0];
  assign bus.sdr_ba        = ba_q;
  assign bus.sdr_addr      = addr_q;
  assign bus.cmd_own       = own_q;
  assign bus.sdr_init_done = done_q;
  assign bus.ref_req       = ref_req;
  assign bus.ref_overrun   = ref_overrun;

endmodule

// File: doc/sdr_init_refresh.md
SDR_INIT_REFRESH -- requirements
Module: sdr_init_refresh

Interface
REQ-001 SHALL have parameter PWRUP_CYCLES, default 20000: power-up cycles with CKE low and NOP before the first command.
REQ-002 SHALL have parameter TRP, default 3: minimum cycles from PRECHARGE to the next command.
REQ-003 SHALL have parameter TRFC, default 7: minimum cycles from AUTO_REFRESH to the next command.
REQ-004 SHALL have parameter TMRD, default 2: cycles from LOAD_MODE_REGISTER to init_done.
REQ-005 SHALL have parameter INIT_REFRESHES, default 2: number of AUTO_REFRESH commands during init; legal range 1..15.
REQ-006 SHALL have parameter MODE_REG, default 13'h033: mode-register value (CAS 3, burst 8).
REQ-007 SHALL have parameter REF_INTERVAL, default 780: cycles between periodic refresh requests.
REQ-008 SHALL have port sdram_clk, input, 1 bit: sole clock; all logic on its rising edge.
REQ-009 SHALL have port sdram_rst, input, 1 bit: reset, synchronous and active-high.
REQ-010 SHALL have port ref_gnt, input, 1 bit: downstream arbiter grants the bus for a refresh.
REQ-011 SHALL have ports sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n and sdr_we_n, each output, 1 bit: registered SDRAM control pins.
REQ-012 SHALL have port sdr_ba, output, 2 bits, and port sdr_addr, output, 13 bits: registered bank and address.
REQ-013 SHALL have port cmd_own, output, 1 bit: this block owns the command bus.
REQ-014 SHALL have port sdr_init_done, output, 1 bit: init complete, sticky until reset.
REQ-015 SHALL have port ref_req, output, 1 bit: periodic refresh pending.
REQ-016 SHALL have port ref_overrun, output, 1 bit: one-cycle pulse when an interval expires while ref_req is already high.

Function
REQ-017 SHALL encode {cs_n,ras_n,cas_n,we_n} as: NOP 0111, PRECHARGE 0010, AUTO_REFRESH 0001, LOAD_MODE_REGISTER 0000.
REQ-018 SHALL implement states PWRUP, PRE, PRE_WAIT, AREF, AREF_WAIT, LMR, LMR_WAIT, DONE, RREF and RREF_WAIT.
REQ-019 SHALL drive every command for exactly one cycle and drive NOP in all other cycles.
REQ-020 SHALL hold PWRUP for PWRUP_CYCLES cycles with sdr_cke=0, then go to PRE; sdr_cke SHALL be 1 in every other state.
REQ-021 SHALL in PRE issue PRECHARGE with sdr_addr[10]=1 (all banks) and sdr_ba=0.
REQ-022 SHALL issue the next command exactly TRP cycles after PRECHARGE.
REQ-023 SHALL issue INIT_REFRESHES AUTO_REFRESH commands spaced exactly TRFC cycles apart.
REQ-024 SHALL issue LOAD_MODE_REGISTER with sdr_addr=MODE_REG and sdr_ba=0 exactly TRFC cycles after the last init refresh.
REQ-025 SHALL assert sdr_init_done exactly TMRD cycles after LOAD_MODE_REGISTER, on entry to DONE.
REQ-026 SHALL hold cmd_own=1 from reset until entry to DONE, and in RREF and RREF_WAIT; cmd_own SHALL be 0 otherwise.
REQ-027 SHALL start the refresh interval timer on DONE entry and restart it on every expiry; expiry is after REF_INTERVAL cycles.
REQ-028 SHALL set ref_req on timer expiry.
REQ-029 SHALL leave ref_req high and pulse ref_overrun for one cycle when the timer expires while ref_req is already high.
REQ-030 SHALL, when ref_gnt=1 and ref_req=1 are sampled in DONE, enter RREF at the next edge.
REQ-031 SHALL in RREF issue AUTO_REFRESH and clear ref_req, then wait TRFC-1 cycles in RREF_WAIT before returning to DONE.
REQ-032 SHALL ignore ref_gnt when ref_req=0 or the state is not DONE.
REQ-033 SHALL give the timer-expiry set priority over the RREF clear when both occur on the same edge, so ref_req stays 1.
REQ-034 SHALL treat ba and addr bits not used by a command as 0 for that command.

Reset
REQ-035 SHALL, on sdram_rst=1 at a clock edge, go to PWRUP and clear all counters.
REQ-036 SHALL reset outputs to: sdr_cke=0, NOP, sdr_ba=0, sdr_addr=0, cmd_own=1, sdr_init_done=0, ref_req=0, ref_overrun=0.
REQ-037 SHALL restart the full init sequence when reset occurs mid-operation, including during RREF.

Configuration
REQ-038 SHALL compile the periodic refresh timer and the RREF and RREF_WAIT states only when SDR_AUTO_REFRESH_EN is defined.
REQ-039 SHALL, without SDR_AUTO_REFRESH_EN, tie ref_req and ref_overrun to 0, ignore ref_gnt and remain in DONE after init.

Structure
REQ-040 SHALL place cmd_t (command encodings) and the state enum in shared package sdr_pkg.
REQ-041 SHALL implement the interval timer together with the ref_req and ref_overrun logic as sub-module sdr_ref_timer.

Verification
With PWRUP_CYCLES=4, TRP=2, TRFC=3, TMRD=2, INIT_REFRESHES=2, REF_INTERVAL=10, and cycle 0 as the first cycle after reset release:
REQ-042 SHALL check the init sequence: cycles 0-3 NOP with cke=0; PRE at cycle 4 with addr[10]=1; AREF at 6 and 9; LMR at 12 with addr=0x033; init_done=1 and cmd_own=0 at 14.
REQ-043 SHALL check periodic refresh: ref_req rises at cycle 24; with ref_gnt=1 at cycle 25, AUTO_REFRESH appears at 26, ref_req=0 at 26, cmd_own=1 for cycles 26-28.
REQ-044 SHALL check overrun: with ref_gnt held 0, ref_req is high at cycle 24 and ref_overrun pulses at cycle 34 only.
REQ-045 SHALL check reset mid-RREF: sdram_rst at cycle 27 gives NOP, cke=0, init_done=0 next cycle, and the init sequence repeats.
REQ-046 SHALL check that ref_gnt=1 with ref_req=0 in DONE issues no command and cmd_own stays 0.
REQ-047 SHALL check that, without SDR_AUTO_REFRESH_EN, ref_req stays 0 for 100 cycles after init_done.
